// File: rtl/amm_pkg.sv
// Shared widths and FSM encoding for the Avalon-MM timeout slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package amm_pkg;

    localparam int AMM_AW  = 32;
    localparam int AMM_DW  = 32;
    localparam int AMM_BEW = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } amm_state_e;

endpackage

// File: rtl/amm_wdog_cnt.sv
// Watchdog counter: counts stalled cycles and flags the cycle on which the limit is reached.
// Latency: expire_o is combinational from the count register and en_i (same cycle).
// Backpressure: none; clr_i has priority over en_i, limit 0 disables expiry.
module amm_wdog_cnt #(
    parameter int unsigned P_LIMIT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [15:0] LIMIT = 16'(P_LIMIT);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Next count: clear wins, otherwise increment and saturate (only reachable with limit 0).
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 16'd0;
        end else if (en_i && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The stalled cycle that would bring the count to LIMIT is the expiring one.
    assign expire_o = en_i && (LIMIT != 16'd0) && (cnt_q == (LIMIT - 16'd1));

endmodule

// File: rtl/amm_timeout_slice.sv
// Registered AMM command/response slice with a hung-slave watchdog and sticky error capture.
// Latency: 3 cycles request-to-completion with a zero-wait slave, +1 per downstream wait cycle.
// Backpressure: upstream stalled except for one RESP cycle; timeout aborts after P_TIMEOUT waits.
module amm_timeout_slice
    import amm_pkg::*;
#(
    parameter int unsigned         P_TIMEOUT  = 1024,
    parameter logic [AMM_DW-1:0]   P_ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic [AMM_AW-1:0]   s_amm_address,
    input  logic [AMM_DW-1:0]   s_amm_writedata,
    input  logic [AMM_BEW-1:0]  s_amm_byteenable,
    input  logic                s_amm_write,
    input  logic                s_amm_read,
    output logic [AMM_DW-1:0]   s_amm_readdata,
    output logic                s_amm_waitrequest,
    output logic [AMM_AW-1:0]   m_amm_address,
    output logic [AMM_DW-1:0]   m_amm_writedata,
    output logic [AMM_BEW-1:0]  m_amm_byteenable,
    output logic                m_amm_write,
    output logic                m_amm_read,
    input  logic [AMM_DW-1:0]   m_amm_readdata,
    input  logic                m_amm_waitrequest,
    input  logic                err_clear,
    output logic                timeout_err,
    output logic [AMM_AW-1:0]   err_addr
);

    amm_state_e          state_q,   state_d;
    logic [AMM_AW-1:0]   addr_q,    addr_d;
    logic [AMM_DW-1:0]   wdata_q,   wdata_d;
    logic [AMM_BEW-1:0]  be_q,      be_d;
    logic                wr_q,      wr_d;
    logic                rd_q,      rd_d;
    logic [AMM_DW-1:0]   rdata_q,   rdata_d;
    logic                swait_q,   swait_d;
    logic                err_q,     err_d;
    logic [AMM_AW-1:0]   erraddr_q, erraddr_d;

    logic cnt_clr;
    logic cnt_en;
    logic expire;

    amm_wdog_cnt #(
        .P_LIMIT (P_TIMEOUT)
    ) u_wdog (
        .clk      (aclk),
        .rst_n    (aresetn),
        .clr_i    (cnt_clr),
        .en_i     (cnt_en),
        .expire_o (expire)
    );

    // FSM next state plus next values of every output register; upstream is released
    // only on the cycle after an accept or an abort.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        rdata_d   = rdata_q;
        swait_d   = 1'b1;
        err_d     = err_q;
        erraddr_d = erraddr_q;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;

        if (err_clear) begin
            err_d     = 1'b0;
            erraddr_d = '0;
        end

        case (state_q)
            ST_IDLE: begin
                if (s_amm_read || s_amm_write) begin
                    addr_d  = s_amm_address;
                    wdata_d = s_amm_writedata;
                    be_d    = s_amm_byteenable;
                    wr_d    = s_amm_write;
                    rd_d    = s_amm_read && !s_amm_write;
                    cnt_clr = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (!m_amm_waitrequest) begin
                    if (rd_q) begin
                        rdata_d = m_amm_readdata;
                    end
                    wr_d    = 1'b0;
                    rd_d    = 1'b0;
                    swait_d = 1'b0;
                    state_d = ST_RESP;
                end else begin
                    cnt_en = 1'b1;
                    if (expire) begin
                        // Hang guard: drop the command on the stuck slave and complete upstream.
                        if (rd_q) begin
                            rdata_d = P_ERR_DATA;
                        end
                        wr_d  = 1'b0;
                        rd_d  = 1'b0;
                        err_d = 1'b1;
                        // A clear in the same cycle makes this the first error again.
                        if (!err_q || err_clear) begin
                            erraddr_d = addr_q;
                        end
                        swait_d = 1'b0;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                // The command still shown upstream this cycle is the one just completed.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, command, response and error registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            rdata_q   <= '0;
            swait_q   <= 1'b1;
            err_q     <= 1'b0;
            erraddr_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            rdata_q   <= rdata_d;
            swait_q   <= swait_d;
            err_q     <= err_d;
            erraddr_q <= erraddr_d;
        end
    end

    assign s_amm_readdata    = rdata_q;
    assign s_amm_waitrequest = swait_q;
    assign m_amm_address     = addr_q;
    assign m_amm_writedata   = wdata_q;
    assign m_amm_byteenable  = be_q;
    assign m_amm_write       = wr_q;
    assign m_amm_read        = rd_q;
    assign timeout_err       = err_q;
    assign err_addr          = erraddr_q;

endmodule

// File: tb/tb_amm_timeout_slice.sv
// Directed bench for amm_timeout_slice: one instance with a short timeout, one with it disabled.
// Latency: n/a.
// Backpressure: bench acts as both upstream master and downstream slave.
module tb_amm_timeout_slice;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic        aresetn;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_be;
    logic        s_wr;
    logic        s_rd;
    logic [31:0] m_rdata;
    logic        m_wait;
    logic        err_clear;

    logic [31:0] s_rdata,   s_rdata_z;
    logic        s_wait,    s_wait_z;
    logic [31:0] m_addr,    m_addr_z;
    logic [31:0] m_wdata,   m_wdata_z;
    logic [3:0]  m_be,      m_be_z;
    logic        m_wr,      m_wr_z;
    logic        m_rd,      m_rd_z;
    logic        terr,      terr_z;
    logic [31:0] eaddr,     eaddr_z;

    amm_timeout_slice #(.P_TIMEOUT(8), .P_ERR_DATA(32'hDEAD_BEEF)) dut (
        .aclk(clk), .aresetn(aresetn),
        .s_amm_address(s_addr), .s_amm_writedata(s_wdata), .s_amm_byteenable(s_be),
        .s_amm_write(s_wr), .s_amm_read(s_rd),
        .s_amm_readdata(s_rdata), .s_amm_waitrequest(s_wait),
        .m_amm_address(m_addr), .m_amm_writedata(m_wdata), .m_amm_byteenable(m_be),
        .m_amm_write(m_wr), .m_amm_read(m_rd),
        .m_amm_readdata(m_rdata), .m_amm_waitrequest(m_wait),
        .err_clear(err_clear), .timeout_err(terr), .err_addr(eaddr)
    );

    amm_timeout_slice #(.P_TIMEOUT(0), .P_ERR_DATA(32'hDEAD_BEEF)) dut_z (
        .aclk(clk), .aresetn(aresetn),
        .s_amm_address(s_addr), .s_amm_writedata(s_wdata), .s_amm_byteenable(s_be),
        .s_amm_write(s_wr), .s_amm_read(s_rd),
        .s_amm_readdata(s_rdata_z), .s_amm_waitrequest(s_wait_z),
        .m_amm_address(m_addr_z), .m_amm_writedata(m_wdata_z), .m_amm_byteenable(m_be_z),
        .m_amm_write(m_wr_z), .m_amm_read(m_rd_z),
        .m_amm_readdata(m_rdata), .m_amm_waitrequest(m_wait),
        .err_clear(err_clear), .timeout_err(terr_z), .err_addr(eaddr_z)
    );

    // Step to just after the next rising edge (input drive point).
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One upstream transfer against the short-timeout instance. Called at a drive point;
    // cycle 1 is the cycle the command is first presented. The slave model holds waitrequest
    // for 'waits' command cycles. Returns completion cycle (0 = bound expired), command
    // cycle count, and the number of command cycles whose m_* did not match the request.
    task automatic xfer(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] be, input logic [31:0] rdata,
                        input int waits, input int clr_cyc,
                        output int done_cyc, output int cmd_cyc, output int bad);
        int held;
        held = 0; done_cyc = 0; cmd_cyc = 0; bad = 0;
        s_rd = rd; s_wr = wr; s_addr = addr; s_wdata = data; s_be = be; m_rdata = rdata;
        for (int c = 1; c <= 200; c++) begin
            if (c > 1) cyc();
            err_clear = (c == clr_cyc);
            if (m_rd || m_wr) begin
                m_wait = (held < waits);
                held++;
            end
            @(negedge clk);
            if (m_rd || m_wr) begin
                cmd_cyc++;
                if (m_addr !== addr || m_wdata !== data || m_be !== be ||
                    m_wr !== wr || m_rd !== (rd & ~wr)) bad++;
            end
            if (s_wait === 1'b0) begin
                done_cyc = c;
                break;
            end
        end
        cyc();
        s_rd = 1'b0; s_wr = 1'b0; err_clear = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0; s_addr = '0; s_wdata = '0; s_be = '0; s_wr = 1'b0; s_rd = 1'b0;
        m_rdata = '0; m_wait = 1'b1; err_clear = 1'b0;
        #12;
        n_tests++; if (s_wait !== 1'b1) begin n_fail++; $display("FAIL reset_swait got=%b exp=1", s_wait); end
        n_tests++; if ({m_rd, m_wr} !== 2'b00) begin n_fail++; $display("FAIL reset_mcmd got=%b exp=00", {m_rd, m_wr}); end
        n_tests++; if (m_addr !== 32'h0 || m_wdata !== 32'h0 || m_be !== 4'h0) begin n_fail++; $display("FAIL reset_mregs got=%h/%h/%h exp=0", m_addr, m_wdata, m_be); end
        n_tests++; if (s_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", s_rdata); end
        n_tests++; if (terr !== 1'b0 || eaddr !== 32'h0) begin n_fail++; $display("FAIL reset_err got=%b/%h exp=0/0", terr, eaddr); end
        @(negedge clk);
        aresetn = 1'b1;
        cyc();
        s_rd = 1'b1; s_addr = 32'h0000_0800;
        cyc();
        s_rd = 1'b0;
        @(negedge clk);
        n_tests++; if (m_rd !== 1'b1) begin n_fail++; $display("FAIL reset_pre_req got=%b exp=1", m_rd); end
        #2 aresetn = 1'b0;
        #1;
        n_tests++; if (m_rd !== 1'b0) begin n_fail++; $display("FAIL reset_midreq_mrd got=%b exp=0", m_rd); end
        n_tests++; if (s_wait !== 1'b1) begin n_fail++; $display("FAIL reset_midreq_swait got=%b exp=1", s_wait); end
        n_tests++; if (terr !== 1'b0 || eaddr !== 32'h0) begin n_fail++; $display("FAIL reset_midreq_err got=%b/%h exp=0/0", terr, eaddr); end
        #1 aresetn = 1'b1;
        cyc();
    endtask

    task automatic test_zero_wait_read();
        int d, c, b;
        xfer(1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'hF, 32'h1234_5678, 0, 0, d, c, b);
        n_tests++; if (d != 3) begin n_fail++; $display("FAIL zw_done_cycle got=%0d exp=3", d); end
        n_tests++; if (c != 1) begin n_fail++; $display("FAIL zw_cmd_cycles got=%0d exp=1", c); end
        n_tests++; if (b != 0) begin n_fail++; $display("FAIL zw_cmd_content got=%0d bad exp=0", b); end
        n_tests++; if (s_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL zw_rdata got=%h exp=12345678", s_rdata); end
        @(negedge clk);
        n_tests++; if ({m_rd, m_wr} !== 2'b00) begin n_fail++; $display("FAIL zw_no_recapture got=%b exp=00", {m_rd, m_wr}); end
        cyc();
    endtask

    task automatic test_write_wait();
        int d, c, b;
        xfer(1'b0, 1'b1, 32'h0000_1100, 32'hCAFE_F00D, 4'b0011, 32'hAAAA_5555, 5, 0, d, c, b);
        n_tests++; if (d != 8) begin n_fail++; $display("FAIL wr_done_cycle got=%0d exp=8", d); end
        n_tests++; if (c != 6) begin n_fail++; $display("FAIL wr_cmd_cycles got=%0d exp=6", c); end
        n_tests++; if (b != 0) begin n_fail++; $display("FAIL wr_cmd_stable got=%0d bad exp=0", b); end
        n_tests++; if (terr !== 1'b0) begin n_fail++; $display("FAIL wr_no_err got=%b exp=0", terr); end
        n_tests++; if (s_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL wr_rdata_held got=%h exp=12345678", s_rdata); end
    endtask

    task automatic test_timeout();
        int d, c, b;
        xfer(1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'hF, 32'h0, 10000, 0, d, c, b);
        n_tests++; if (d != 10) begin n_fail++; $display("FAIL to_done_cycle got=%0d exp=10", d); end
        n_tests++; if (c != 8) begin n_fail++; $display("FAIL to_cmd_cycles got=%0d exp=8", c); end
        n_tests++; if (s_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL to_rdata got=%h exp=deadbeef", s_rdata); end
        n_tests++; if (terr !== 1'b1) begin n_fail++; $display("FAIL to_err got=%b exp=1", terr); end
        n_tests++; if (eaddr !== 32'h0000_2000) begin n_fail++; $display("FAIL to_err_addr got=%h exp=00002000", eaddr); end
    endtask

    task automatic test_err_sticky();
        int d, c, b;
        xfer(1'b0, 1'b1, 32'h0000_3000, 32'h0101_0101, 4'hF, 32'h0, 10000, 0, d, c, b);
        n_tests++; if (d != 10) begin n_fail++; $display("FAIL st2_done_cycle got=%0d exp=10", d); end
        n_tests++; if (terr !== 1'b1 || eaddr !== 32'h0000_2000) begin n_fail++; $display("FAIL st2_err_keep got=%b/%h exp=1/00002000", terr, eaddr); end
        n_tests++; if (s_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL st2_rdata_held got=%h exp=deadbeef", s_rdata); end
        // Clear asserted exactly in the aborting cycle (8th REQ cycle = cycle 9).
        xfer(1'b1, 1'b0, 32'h0000_4000, 32'h0, 4'hF, 32'h0, 10000, 9, d, c, b);
        n_tests++; if (terr !== 1'b1) begin n_fail++; $display("FAIL st3_clr_vs_to_err got=%b exp=1", terr); end
        n_tests++; if (eaddr !== 32'h0000_4000) begin n_fail++; $display("FAIL st3_clr_vs_to_addr got=%h exp=00004000", eaddr); end
        err_clear = 1'b1;
        cyc();
        err_clear = 1'b0;
        @(negedge clk);
        n_tests++; if (terr !== 1'b0 || eaddr !== 32'h0) begin n_fail++; $display("FAIL clr_alone got=%b/%h exp=0/0", terr, eaddr); end
        cyc();
        err_clear = 1'b1;
        cyc();
        err_clear = 1'b0;
        @(negedge clk);
        n_tests++; if (terr !== 1'b0 || eaddr !== 32'h0 || s_wait !== 1'b1) begin n_fail++; $display("FAIL clr_idle got=%b/%h/%b exp=0/0/1", terr, eaddr, s_wait); end
        cyc();
    endtask

    task automatic test_back_to_back();
        int d, c, b;
        xfer(1'b1, 1'b1, 32'h0000_5000, 32'h1111_2222, 4'hF, 32'h9999_9999, 0, 0, d, c, b);
        n_tests++; if (d != 3 || c != 1) begin n_fail++; $display("FAIL b2b1_timing got=%0d/%0d exp=3/1", d, c); end
        n_tests++; if (b != 0) begin n_fail++; $display("FAIL b2b1_write_wins got=%0d bad exp=0", b); end
        n_tests++; if (s_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL b2b1_rdata_held got=%h exp=deadbeef", s_rdata); end
        xfer(1'b1, 1'b0, 32'h0000_5004, 32'h0, 4'hF, 32'h600D_F00D, 0, 0, d, c, b);
        n_tests++; if (d != 3 || c != 1) begin n_fail++; $display("FAIL b2b2_timing got=%0d/%0d exp=3/1", d, c); end
        n_tests++; if (b != 0) begin n_fail++; $display("FAIL b2b2_no_dup got=%0d bad exp=0", b); end
        n_tests++; if (s_rdata !== 32'h600D_F00D) begin n_fail++; $display("FAIL b2b2_rdata got=%h exp=600df00d", s_rdata); end
        @(negedge clk);
        n_tests++; if ({m_rd, m_wr} !== 2'b00) begin n_fail++; $display("FAIL b2b_idle got=%b exp=00", {m_rd, m_wr}); end
        cyc();
    endtask

    task automatic test_no_timeout();
        int bad;
        @(negedge clk);
        aresetn = 1'b0;
        #1 aresetn = 1'b1;
        cyc();
        m_wait = 1'b1;
        s_rd = 1'b1; s_addr = 32'h0000_7000;
        cyc();
        s_rd = 1'b0;
        bad = 0;
        for (int i = 0; i < 70000; i++) begin
            @(negedge clk);
            if (s_wait_z !== 1'b1 || m_rd_z !== 1'b1 || terr_z !== 1'b0) bad++;
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL nto_stall_held got=%0d bad cycles exp=0", bad); end
        cyc();
        m_wait = 1'b0; m_rdata = 32'h55AA_55AA;
        cyc();
        @(negedge clk);
        n_tests++; if (s_wait_z !== 1'b0) begin n_fail++; $display("FAIL nto_complete got=%b exp=0", s_wait_z); end
        n_tests++; if (s_rdata_z !== 32'h55AA_55AA) begin n_fail++; $display("FAIL nto_rdata got=%h exp=55aa55aa", s_rdata_z); end
        n_tests++; if (terr_z !== 1'b0 || eaddr_z !== 32'h0) begin n_fail++; $display("FAIL nto_err got=%b/%h exp=0/0", terr_z, eaddr_z); end
        cyc();
    endtask

    initial begin
        test_reset();
        test_zero_wait_read();
        test_write_wait();
        test_timeout();
        test_err_sticky();
        test_back_to_back();
        test_no_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
